// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core constants, load encodings and writeback entry type
package core_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - combinational byte/half/word select and sign/zero extension of load data
module load_extend
  import core_pkg::*;
(
  input  logic [XLEN-1:0] ld_data,
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_addr_lo,
  output logic [XLEN-1:0] data,
  output logic            err
);

  logic [7:0]  b;
  logic [15:0] h;

  assign b = ld_data[{ld_addr_lo, 3'b000} +: 8];
  assign h = ld_data[{ld_addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    data = '0;
    err  = 1'b0;
    case (ld_funct3)
      F3_LB:   data = {{(XLEN-8){b[7]}}, b};
      F3_LBU:  data = {{(XLEN-8){1'b0}}, b};
      F3_LH:   data = {{(XLEN-16){h[15]}}, h};
      F3_LHU:  data = {{(XLEN-16){1'b0}}, h};
      F3_LW:   data = ld_data;
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - regfile write port arbiter for ALU and load results with pending-load scoreboard
module regfile_writeback
  import core_pkg::*;
#(
  parameter int XLEN     = core_pkg::XLEN,
  parameter int NREG     = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_result,
  output logic              alu_stall,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [REG_AW-1:0] ld_rd,
  input  logic [XLEN-1:0]   ld_data,
  input  logic [2:0]        ld_funct3,
  input  logic [1:0]        ld_addr_lo,
  input  logic              iss_valid,
  input  logic [REG_AW-1:0] iss_rd,
  output logic              we,
  output logic [REG_AW-1:0] wa,
  output logic [XLEN-1:0]   write,
  output logic [NREG-1:0]   pending,
  output logic              ld_err
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  logic              hold_valid;
  wb_entry_t         hold;
  logic [WAIT_W-1:0] wait_cnt;

  logic [XLEN-1:0] ext_data;
  logic            ext_err;
  logic            alu_need;
  logic            starved;
  logic            load_win;
  logic            alu_win;
  logic            accept;
  logic [NREG-1:0] pending_nxt;

  load_extend u_load_extend (
    .ld_data    (ld_data),
    .ld_funct3  (ld_funct3),
    .ld_addr_lo (ld_addr_lo),
    .data       (ext_data),
    .err        (ext_err)
  );

  assign alu_need  = alu_valid && (alu_rd != '0);
  assign starved   = hold_valid && (wait_cnt >= WAIT_W'(MAX_WAIT));
  assign load_win  = hold_valid && (starved || !alu_need);
  assign alu_win   = alu_need && !load_win;
  assign alu_stall = rst && alu_need && load_win;
  assign ld_ready  = rst && !hold_valid;
  assign accept    = ld_valid && ld_ready;

  // Clear on load writeback first so a same-edge re-issue keeps the bit set.
  always_comb begin
    pending_nxt = pending;
    if (load_win)
      pending_nxt[hold.rd] = 1'b0;
    if (iss_valid && (iss_rd != '0))
      pending_nxt[iss_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      we         <= 1'b0;
      wa         <= '0;
      write      <= '0;
      pending    <= '0;
      ld_err     <= 1'b0;
      hold_valid <= 1'b0;
      hold       <= '0;
      wait_cnt   <= '0;
    end else begin
      pending <= pending_nxt;
      ld_err  <= accept && ext_err;
      if (load_win) begin
        we         <= 1'b1;
        wa         <= hold.rd;
        write      <= hold.data;
        hold_valid <= 1'b0;
        wait_cnt   <= '0;
      end else if (alu_win) begin
        we    <= 1'b1;
        wa    <= alu_rd;
        write <= alu_result;
        if (hold_valid && (wait_cnt < WAIT_W'(MAX_WAIT)))
          wait_cnt <= wait_cnt + 1'b1;
      end else begin
        we <= 1'b0;
      end
      // ld_ready implies the hold is empty, so this never collides with a drain.
      if (accept && (ld_rd != '0)) begin
        hold_valid <= 1'b1;
        hold.rd    <= ld_rd;
        hold.data  <= ext_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// tb/tb_regfile_writeback.sv - directed self-checking bench for regfile_writeback
module tb_regfile_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_result;
  logic        alu_stall;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] write;
  logic [31:0] pending;
  logic        ld_err;

  int total = 0;
  int bad   = 0;

  regfile_writeback dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_result (alu_result),
    .alu_stall  (alu_stall),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_rd      (ld_rd),
    .ld_data    (ld_data),
    .ld_funct3  (ld_funct3),
    .ld_addr_lo (ld_addr_lo),
    .iss_valid  (iss_valid),
    .iss_rd     (iss_rd),
    .we         (we),
    .wa         (wa),
    .write      (write),
    .pending    (pending),
    .ld_err     (ld_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_in(input logic [4:0] rd, input logic [31:0] d, input logic [2:0] f3,
                         input logic [1:0] lo);
    ld_valid = 1'b1; ld_rd = rd; ld_data = d; ld_funct3 = f3; ld_addr_lo = lo;
    #1 chk("ld_ready_accept", ld_ready, 1);
    tick();
    ld_valid = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic [31:0] exp;
    logic        err;
  } ext_vec_t;

  ext_vec_t ev[8];

  initial begin
    ev[0] = '{3'b000, 2'd0, 32'hFFFFFF81, 1'b0};
    ev[1] = '{3'b100, 2'd3, 32'h00000080, 1'b0};
    ev[2] = '{3'b001, 2'd2, 32'hFFFF80F0, 1'b0};
    ev[3] = '{3'b101, 2'd0, 32'h00007F81, 1'b0};
    ev[4] = '{3'b010, 2'd0, 32'h80F07F81, 1'b0};
    ev[5] = '{3'b011, 2'd0, 32'h00000000, 1'b1};
    ev[6] = '{3'b000, 2'd1, 32'h0000007F, 1'b0};
    ev[7] = '{3'b100, 2'd2, 32'h000000F0, 1'b0};

    rst = 1'b0; iss_valid = 1'b0; iss_rd = '0;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_result = 32'h12345678;
    ld_valid = 1'b1; ld_rd = 5'd1; ld_data = 32'h1; ld_funct3 = 3'b010; ld_addr_lo = 2'd0;

    // 1: reset hold
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rst_ld_ready", ld_ready, 0);
      chk("rst_alu_stall", alu_stall, 0);
      tick();
      chk("rst_we", we, 0);
      chk("rst_pending", pending, 0);
      chk("rst_ld_err", ld_err, 0);
    end
    rst = 1'b1; ld_valid = 1'b0;
    tick();
    chk("alu_first_we", we, 1);
    chk("alu_first_wa", wa, 5);
    chk("alu_first_write", write, 32'h12345678);
    alu_valid = 1'b0;
    tick();
    chk("idle_we", we, 0);

    // 2: extension
    for (int i = 0; i < 8; i++) begin
      load_in(5'd10, 32'h80F07F81, ev[i].f3, ev[i].lo);
      #1 chk("ext_hold_full", ld_ready, 0);
      chk($sformatf("ext_err_%0d", i), ld_err, ev[i].err);
      tick();
      chk($sformatf("ext_we_%0d", i), we, 1);
      chk($sformatf("ext_wa_%0d", i), wa, 10);
      chk($sformatf("ext_data_%0d", i), write, ev[i].exp);
      chk($sformatf("ext_err_clr_%0d", i), ld_err, 0);
    end

    // 3: contention and starvation
    load_in(5'd7, 32'hCAFE0007, 3'b010, 2'd0);
    alu_valid = 1'b1; alu_rd = 5'd3;
    for (int i = 0; i < 4; i++) begin
      alu_result = 32'h100 + i;
      #1 chk("cont_no_stall", alu_stall, 0);
      tick();
      chk("cont_alu_wa", wa, 3);
      chk("cont_alu_write", write, 32'h100 + i);
    end
    alu_result = 32'h200;
    #1 chk("starve_stall", alu_stall, 1);
    tick();
    chk("starve_we", we, 1);
    chk("starve_wa", wa, 7);
    chk("starve_write", write, 32'hCAFE0007);
    #1 chk("retry_no_stall", alu_stall, 0);
    tick();
    chk("retry_wa", wa, 3);
    chk("retry_write", write, 32'h200);
    alu_valid = 1'b0;

    // 4: x0 suppression
    load_in(5'd12, 32'h00000055, 3'b010, 2'd0);
    alu_valid = 1'b1; alu_rd = 5'd0; alu_result = 32'hDEAD;
    #1 chk("x0_alu_no_stall", alu_stall, 0);
    tick();
    chk("x0_load_we", we, 1);
    chk("x0_load_wa", wa, 12);
    chk("x0_load_write", write, 32'h55);
    tick();
    chk("x0_alu_no_we", we, 0);
    alu_valid = 1'b0;
    load_in(5'd0, 32'h77, 3'b010, 2'd0);
    #1 chk("x0_hold_empty", ld_ready, 1);
    tick();
    chk("x0_load_no_we", we, 0);

    // 5: scoreboard
    iss_valid = 1'b1; iss_rd = 5'd9;
    tick();
    iss_valid = 1'b0;
    chk("sb_set", pending, 32'h200);
    load_in(5'd9, 32'h9, 3'b010, 2'd0);
    iss_valid = 1'b1;
    tick();
    iss_valid = 1'b0;
    chk("sb_wb_wa", wa, 9);
    chk("sb_set_wins", pending, 32'h200);
    load_in(5'd9, 32'h99, 3'b010, 2'd0);
    tick();
    chk("sb_clear", pending, 0);
    iss_valid = 1'b1; iss_rd = 5'd0;
    tick();
    iss_valid = 1'b0;
    chk("sb_x0", pending, 0);

    // 6: mid-operation reset
    load_in(5'd4, 32'h44, 3'b010, 2'd0);
    alu_valid = 1'b1; alu_rd = 5'd3; alu_result = 32'h333;
    tick();
    tick();
    chk("mid_alu_wa", wa, 3);
    rst = 1'b0;
    #1 chk("mid_rst_ld_ready", ld_ready, 0);
    tick();
    chk("mid_rst_we", we, 0);
    rst = 1'b1;
    #1 chk("mid_rel_ld_ready", ld_ready, 1);
    chk("mid_rel_no_stall", alu_stall, 0);
    tick();
    chk("mid_rel_alu_wa", wa, 3);
    alu_valid = 1'b0;
    tick();
    chk("mid_no_x4", we, 0);
    tick();
    chk("mid_still_idle", we, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Write-side companion of the 32x32 register file. It owns the single regfile write port and drives we/wa/write into it.
- Merges two result sources into that port:
  - single-cycle ALU results;
  - load-unit results, which arrive via a valid/ready handshake and are sign/zero-extended here.
- Keeps a per-register pending-load scoreboard so issue logic can stall on RAW hazards against outstanding loads.

Parameters:
- XLEN, 32, data width of results and regfile words.
- NREG, 32, number of architectural registers; address width is log2(NREG) = 5.
- MAX_WAIT, 4, cycles a held load may lose arbitration before it takes priority over the ALU.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- alu_valid  in  1  ALU result present this cycle.
- alu_rd  in  5  ALU destination register.
- alu_result  in  XLEN  ALU result.
- alu_stall  out  1  combinational; ALU must hold its inputs and retry next cycle.
- ld_valid  in  1  load unit offers a result.
- ld_ready  out  1  combinational; block accepts the load this cycle.
- ld_rd  in  5  load destination register.
- ld_data  in  XLEN  raw aligned memory word.
- ld_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- ld_addr_lo  in  2  byte offset within the word.
- iss_valid  in  1  a load is issued to memory this cycle.
- iss_rd  in  5  destination of the issued load.
- we  out  1  registered regfile write enable; also serves as the bypass-valid signal.
- wa  out  5  registered regfile write address.
- write  out  XLEN  registered regfile write data.
- pending  out  NREG  registered scoreboard; bit i set means a load to xi is outstanding.
- ld_err  out  1  registered one-cycle pulse on an unsupported funct3.

Behaviour:
- Reset (rst==0 at an edge): we=0, wa=0, write=0, pending=0, ld_err=0, hold buffer emptied, wait_cnt=0.
  - ld_ready=0 and alu_stall=0 while rst==0.
  - A held load lost to a mid-operation reset is not written and raises no error.
- Hold buffer: one entry (hold_valid, hold_rd, hold_data).
  - ld_ready = rst & ~hold_valid.
  - On ld_valid & ld_ready the extended data is stored; hold_valid=1 next cycle.
  - If ld_rd==0, the handshake completes but nothing is stored.
- Extension, using byte b = ld_data[8*ld_addr_lo +: 8] and half h = ld_data[16*ld_addr_lo[1] +: 16]:
  - LB = sext(b), LBU = zext(b), LH = sext(h), LHU = zext(h), LW = ld_data.
  - Other funct3 values: the entry is stored with data 0 and ld_err pulses the next cycle.
  - Misalignment is not checked in this block.
- Arbitration, evaluated each cycle. The ALU "needs the port" when alu_valid & alu_rd!=0.
  - If hold_valid & wait_cnt>=MAX_WAIT: the load wins. alu_stall = alu_valid & alu_rd!=0.
  - Else if the ALU needs the port: the ALU wins. If hold_valid, wait_cnt increments (saturating).
  - Else if hold_valid: the load wins.
  - Otherwise: no write.
  - An ALU result with rd==0 never needs the port and is never stalled.
- Output stage: the winner registers into we/wa/write at the next edge; if there is no winner, we=0 and wa/write hold their values.
  - When the held load wins: hold_valid=0 and wait_cnt=0 at that edge.
  - A new load can be accepted in the same cycle the hold drains only from the following cycle, because ld_ready depends on hold_valid.
- Latency:
  - ALU: valid at cycle N gives we at N+1.
  - Load, uncontended: accepted at N, in hold at N+1, we at N+2.
- Scoreboard:
  - iss_valid & iss_rd!=0 sets pending[iss_rd] at the next edge.
  - A load writeback clears pending[wa] on the edge where it enters we/wa.
  - Set and clear of the same register on the same edge: set wins.
  - pending[0] is always 0.
  - ALU writes never touch pending.
- Consumers read the regfile asynchronously; the regfile commits on the edge after we. Decode must therefore forward from write when we & wa==rs.

Decomposition:
- Shared package core_pkg:
  - XLEN and register address width constants.
  - funct3 load encodings (LB, LH, LW, LBU, LHU).
  - a wb_entry typedef {rd, data}.
- Sub-module load_extend: combinational extender taking (ld_data, ld_funct3, ld_addr_lo) and producing (data, err). It is reused later by a store-to-load forwarding path.
- Arbiter, hold buffer, wait counter, output register and scoreboard stay in the top module.

Test Plan:
1. Reset hold: rst=0 for 3 cycles with alu_valid=1, ld_valid=1 -> we=0, ld_ready=0, pending=0. After release, the first ALU result (rd=5, 0x12345678) gives we=1, wa=5, write=0x12345678 one cycle later.
2. Extension: ld_data=0x80F0_7F81, each funct3 and offset in turn:
   - LB at offset 0 -> 0xFFFFFF81.
   - LBU at offset 3 -> 0x00000080.
   - LH at offset 2 -> 0xFFFF80F0.
   - LHU at offset 0 -> 0x00007F81.
   - LW -> 0x80F07F81.
   - funct3=011 -> write=0 and a one-cycle ld_err pulse.
3. Contention and starvation: hold loaded (rd=7) with the ALU valid every cycle to rd=3 -> ALU wins 4 cycles, then the load writes wa=7 with alu_stall=1 for exactly that cycle. The ALU result is written the next cycle.
4. x0 suppression: ALU rd=0 with a held load present -> the load writes that cycle and the ALU is not stalled. Load rd=0 -> handshake completes, we stays 0, hold stays empty.
5. Scoreboard: issue rd=9, then the load writeback to 9 while iss_valid re-issues rd=9 on the same edge -> pending[9] stays 1. A later writeback with no re-issue -> pending[9]=0.
6. Mid-operation reset: load held (rd=4) and losing arbitration, rst=0 for one cycle -> no write to x4, hold_valid=0, wait_cnt=0, and ld_ready=1 on the first cycle after release.
